// File: rtl/demux_sched_pkg.sv
// Shared constants and helpers for the 1:4 demux burst scheduler and its arbiter pieces.
package demux_sched_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [SEL_W-1:0] ch);
        return NUM_CH'(1) << ch;
    endfunction

endpackage

// File: rtl/demux_rr_next_sel.sv
// Round-robin successor search: first enabled channel after sel_i, wrapping; sel_i itself if none.
module demux_rr_next_sel
    import demux_sched_pkg::*;
(
    input  logic [SEL_W-1:0]  sel_i,
    input  logic [NUM_CH-1:0] en_mask_i,
    output logic [SEL_W-1:0]  next_sel_o
);

    logic [SEL_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest enabled channel wins.
    always_comb begin
        next_sel_o = sel_i;
        idx        = '0;
        for (int k = NUM_CH - 1; k >= 1; k--) begin
            idx = sel_i + SEL_W'(k);
            if (en_mask_i[idx]) next_sel_o = idx;
        end
    end

endmodule

// File: rtl/demux_burst_scheduler.sv
// Spreads one valid/ready stream over 4 channels in BURST_LEN-beat round-robin bursts or a forced channel.
module demux_burst_scheduler
    import demux_sched_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [3:0]        en_mask_i,
    input  logic              force_en_i,
    input  logic [1:0]        force_sel_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic [3:0]        out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic [3:0]        out_ready_i,
    output logic [1:0]        cur_sel_o,
    output logic [CNT_W-1:0]  beat_cnt_o
);

    logic [0:0]        state_q, state_d;
    logic [SEL_W-1:0]  cur_sel_q, cur_sel_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              force_q;
    logic              hold_vld_q, hold_vld_d;
    logic [SEL_W-1:0]  hold_ch_q, hold_ch_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;

    logic              any_src, sel_ok, drain, accept, last_beat;
    logic [SEL_W-1:0]  search_base, next_sel;
    logic [CNT_W-1:0]  cnt_base;

    assign any_src = (|en_mask_i) | force_en_i;
    assign sel_ok  = force_en_i | en_mask_i[cur_sel_q];
    assign drain   = hold_vld_q & out_ready_i[hold_ch_q];

    assign in_ready_o = rst_n_i & (state_q == ST_RUN) & sel_ok & (!hold_vld_q | drain);
    assign accept     = in_valid_i & in_ready_o;

    // From IDLE, searching after the last channel yields the lowest enabled channel.
    assign search_base = (state_q == ST_IDLE) ? SEL_W'(NUM_CH - 1) : cur_sel_q;

    // Leaving force mode restarts the burst count on the channel we were pinned to.
    assign cnt_base  = (force_q & !force_en_i) ? '0 : beat_cnt_q;
    assign last_beat = (cnt_base == CNT_W'(BURST_LEN - 1));

    demux_rr_next_sel u_next_sel (
        .sel_i      (search_base),
        .en_mask_i  (en_mask_i),
        .next_sel_o (next_sel)
    );

    always_comb begin
        state_d    = state_q;
        cur_sel_d  = cur_sel_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_src) begin
                    state_d    = ST_RUN;
                    cur_sel_d  = force_en_i ? force_sel_i : next_sel;
                    beat_cnt_d = '0;
                end
            end
            default: begin
                if (!any_src) begin
                    state_d    = ST_IDLE;
                    beat_cnt_d = '0;
                end else if (force_en_i) begin
                    cur_sel_d = force_sel_i;
                    if (accept) beat_cnt_d = last_beat ? '0 : cnt_base + CNT_W'(1);
                end else if (!sel_ok) begin
                    cur_sel_d  = next_sel;
                    beat_cnt_d = '0;
                end else if (accept) begin
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        cur_sel_d  = next_sel;
                    end else begin
                        beat_cnt_d = cnt_base + CNT_W'(1);
                    end
                end else begin
                    beat_cnt_d = cnt_base;
                end
            end
        endcase
    end

    // Captured channel is frozen with the beat, so later mask/force changes cannot redirect it.
    always_comb begin
        hold_vld_d  = hold_vld_q & !drain;
        hold_ch_d   = hold_ch_q;
        hold_data_d = hold_data_q;
        if (accept) begin
            hold_vld_d  = 1'b1;
            hold_ch_d   = force_en_i ? force_sel_i : cur_sel_q;
            hold_data_d = in_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            cur_sel_q   <= '0;
            beat_cnt_q  <= '0;
            force_q     <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_ch_q   <= '0;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_sel_q   <= cur_sel_d;
            beat_cnt_q  <= beat_cnt_d;
            force_q     <= force_en_i;
            hold_vld_q  <= hold_vld_d;
            hold_ch_q   <= hold_ch_d;
            hold_data_q <= hold_data_d;
        end
    end

    assign out_valid_o = hold_vld_q ? ch_onehot(hold_ch_q) : '0;
    assign out_data_o  = hold_data_q;
    assign cur_sel_o   = cur_sel_q;
    assign beat_cnt_o  = beat_cnt_q;

endmodule

// File: tb/tb_demux_burst_scheduler.sv
// Scoreboard bench: driver queues expected {channel, data}; a negedge monitor checks every drained beat.
module tb_demux_burst_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] en_mask;
    logic       force_en;
    logic [1:0] force_sel;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [3:0] out_valid;
    logic [7:0] out_data;
    logic [3:0] out_ready;
    logic [1:0] cur_sel;
    logic [1:0] beat_cnt;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   last_wait;
    int   stalls;

    always #5 clk = ~clk;

    demux_burst_scheduler #(.DATA_W(8), .BURST_LEN(4), .CNT_W(2)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .en_mask_i   (en_mask),
        .force_en_i  (force_en),
        .force_sel_i (force_sel),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready),
        .cur_sel_o   (cur_sel),
        .beat_cnt_o  (beat_cnt)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Offer one beat; record its expected destination once the DUT shows ready.
    task automatic send(input logic [7:0] d, input logic [1:0] ch, input bit push);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: data %0h got no ready, expected ready within 40 cycles", d);
        end else if (push) begin
            sb.push_back('{ch: ch, d: d});
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        last_wait = waited;
    endtask

    always @(negedge clk) begin
        int   ch;
        exp_t e;
        if (rst_n && out_valid != 4'b0) begin
            check("out_valid_onehot", $countones(out_valid), 1);
            ch = 0;
            for (int k = 0; k < 4; k++) if (out_valid[k]) ch = k;
            if (out_ready[ch]) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got ch%0d data %0h, expected no beat", ch, out_data);
                end else begin
                    e = sb.pop_front();
                    check("beat_ch", ch, e.ch);
                    check("beat_data", out_data, e.d);
                end
            end
        end
    end

    initial begin
        int t;
        rst_n = 1'b0; en_mask = 4'h0; force_en = 1'b0; force_sel = 2'd0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_cur_sel", cur_sel, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        check("rst_out_data", out_data, 0);
        en_mask = 4'hF;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Four full bursts over all channels.
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            send(8'(i), 2'(i / 4), 1);
            if (last_wait != 0) stalls++;
            if (i == 5) begin
                check("t1_cur_sel_mid", cur_sel, 1);
                check("t1_beat_cnt_mid", beat_cnt, 2);
            end
        end
        check("t1_full_throughput", stalls, 0);

        // Only ch1/ch3 enabled.
        en_mask = 4'b1010;
        repeat (2) @(posedge clk); #1;
        for (int i = 0; i < 12; i++) send(8'h20 + 8'(i), (i / 4 == 1) ? 2'd3 : 2'd1, 1);

        // Sink stall on ch0.
        en_mask = 4'b0001;
        repeat (2) @(posedge clk); #1;
        out_ready = 4'b1110;
        send(8'h30, 2'd0, 1);
        in_valid = 1'b1;
        in_data  = 8'h31;
        repeat (5) begin
            @(negedge clk);
            check("t3_stall_valid", out_valid, 4'b0001);
            check("t3_stall_data", out_data, 8'h30);
            check("t3_stall_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 4'hF;
        send(8'h31, 2'd0, 1);
        check("t3_release_ready", last_wait, 0);
        send(8'h32, 2'd0, 1);
        send(8'h33, 2'd0, 1);

        // Channel disabled mid-burst.
        en_mask = 4'b0110;
        repeat (2) @(posedge clk); #1;
        send(8'h40, 2'd1, 1);
        send(8'h41, 2'd1, 1);
        en_mask = 4'b0100;
        @(posedge clk); #1;
        check("t4_cur_sel_skip", cur_sel, 2);
        check("t4_beat_cnt_reset", beat_cnt, 0);
        send(8'h42, 2'd2, 1);
        send(8'h43, 2'd2, 1);

        // Forced channel overrides mask.
        en_mask = 4'b0011; force_en = 1'b1; force_sel = 2'd2;
        for (int i = 0; i < 10; i++) send(8'h50 + 8'(i), 2'd2, 1);
        check("t5_force_cur_sel", cur_sel, 2);
        check("t5_force_beat_cnt", beat_cnt, 0);
        en_mask = 4'b0000; force_en = 1'b0;
        repeat (2) @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        repeat (3) begin
            @(negedge clk);
            check("t5_idle_in_ready", in_ready, 0);
            check("t5_idle_out_valid", out_valid, 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;

        // Reset with a beat held: the beat must vanish.
        en_mask = 4'b0100;
        repeat (2) @(posedge clk); #1;
        out_ready = 4'b0000;
        send(8'h60, 2'd2, 0);
        check("t6_held_valid", out_valid, 4'b0100);
        check("t6_held_cnt", beat_cnt, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_cur_sel", cur_sel, 0);
        check("t6_rst_beat_cnt", beat_cnt, 0);
        check("t6_rst_in_ready", in_ready, 0);
        rst_n = 1'b1; out_ready = 4'hF; en_mask = 4'b0000;
        repeat (5) @(posedge clk);

        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
